// File: rtl/udp_tx_segmenter.sv
// Splits descriptor-framed messages into datagrams of at most MAX_SEG_BEATS beats,
// tagging every beat with the connection id and trimming byte enables on the final beat.
module udp_tx_segmenter #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned CONN_ID_WIDTH = 18,
  parameter int unsigned MAX_SEG_BEATS = 22
) (
  input  logic                     tx_axis_aclk,
  input  logic                     tx_axis_rst,
  input  logic                     s_desc_tvalid,
  output logic                     s_desc_tready,
  input  logic [CONN_ID_WIDTH-1:0] s_desc_conn_id,
  input  logic [15:0]              s_desc_len,
  input  logic                     s_data_tvalid,
  output logic                     s_data_tready,
  input  logic                     s_data_tlast,
  input  logic [DATA_WIDTH-1:0]    s_data_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_data_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [543:0]             m_axis_tdata,
  output logic [67:0]              m_axis_tstrb,
  output logic                     err_len_mismatch
);

  localparam int unsigned PAY_W     = 512;
  localparam int unsigned PAY_BYTES = 64;
  localparam int unsigned CONN_W    = 18;
  localparam int unsigned OUT_W     = 544;
  localparam int unsigned STRB_W    = 68;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned SEG_W     = $clog2(MAX_SEG_BEATS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                   state, state_next;
  logic [CONN_ID_WIDTH-1:0] conn_id_q;
  logic [LEN_W-1:0]         rem_bytes;
  logic [SEG_W-1:0]         seg_beat;

  logic                     desc_fire, beat_fire;
  logic                     final_c, last_c, err_c;
  logic [PAY_BYTES-1:0]     mask_c;
  logic [OUT_W-1:0]         tdata_c;
  logic [STRB_W-1:0]        tstrb_c;

  // Beat formatting: final beat keeps only the lowest rem_bytes byte enables.
  always_comb begin
    final_c = (rem_bytes <= LEN_W'(PAY_BYTES));
    last_c  = final_c || s_data_tlast || (seg_beat == SEG_W'(MAX_SEG_BEATS - 1));
    err_c   = (final_c != s_data_tlast);
    mask_c  = '0;
    for (int unsigned i = 0; i < PAY_BYTES; i++) begin
      mask_c[i] = (i < 32'(rem_bytes));
    end
    tdata_c                     = '0;
    tdata_c[PAY_W-1:0]          = PAY_W'(s_data_tdata);
    tdata_c[PAY_W +: CONN_W]    = CONN_W'(conn_id_q);
    tstrb_c                     = '0;
    tstrb_c[PAY_BYTES-1:0]      = final_c ? (PAY_BYTES'(s_data_tkeep) & mask_c)
                                          : PAY_BYTES'(s_data_tkeep);
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next    = state;
    s_desc_tready = 1'b0;
    s_data_tready = 1'b0;
    desc_fire     = 1'b0;
    beat_fire     = 1'b0;
    if (!tx_axis_rst) begin
      case (state)
        IDLE: begin
          s_desc_tready = 1'b1;
          if (s_desc_tvalid) begin
            desc_fire = 1'b1;
            if (s_desc_len != '0) state_next = STREAM;
          end
        end
        STREAM: begin
          s_data_tready = !m_axis_tvalid || m_axis_tready;
          if (s_data_tvalid && s_data_tready) begin
            beat_fire = 1'b1;
            if (s_data_tlast)  state_next = IDLE;
            else if (final_c)  state_next = DRAIN;
          end
        end
        DRAIN: begin
          s_data_tready = 1'b1;
          if (s_data_tvalid && s_data_tlast) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_rst) state <= IDLE;
    else             state <= state_next;
  end

  // Message counters and the single output register stage.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_rst) begin
      conn_id_q        <= '0;
      rem_bytes        <= '0;
      seg_beat         <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tstrb     <= '0;
      err_len_mismatch <= 1'b0;
    end else begin
      err_len_mismatch <= beat_fire && err_c;
      if (desc_fire) begin
        conn_id_q <= s_desc_conn_id;
        rem_bytes <= s_desc_len;
        seg_beat  <= '0;
      end
      if (beat_fire) begin
        rem_bytes     <= final_c ? '0 : rem_bytes - LEN_W'(PAY_BYTES);
        seg_beat      <= last_c ? '0 : seg_beat + SEG_W'(1);
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= last_c;
        m_axis_tdata  <= tdata_c;
        m_axis_tstrb  <= tstrb_c;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_segmenter.sv
// Directed bench for udp_tx_segmenter: segmentation, byte trimming, length errors,
// backpressure hold and mid-message reset.
module tb_udp_tx_segmenter;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_desc_tvalid, s_desc_tready;
  logic [17:0]  s_desc_conn_id;
  logic [15:0]  s_desc_len;
  logic         s_data_tvalid, s_data_tready, s_data_tlast;
  logic [511:0] s_data_tdata;
  logic [63:0]  s_data_tkeep;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [543:0] m_axis_tdata;
  logic [67:0]  m_axis_tstrb;
  logic         err_len_mismatch;

  int total = 0;
  int bad   = 0;
  bit toggle_ready = 1'b0;

  logic [31:0] q_tag[$];
  logic [17:0] q_conn[$];
  logic [63:0] q_strb[$];
  logic        q_last[$];
  int          err_cycles, err_pulses;
  bit          prev_stall, prev_err;
  logic [63:0] prev_data;

  udp_tx_segmenter dut (
    .tx_axis_aclk     (clk),
    .tx_axis_rst      (rst),
    .s_desc_tvalid    (s_desc_tvalid),
    .s_desc_tready    (s_desc_tready),
    .s_desc_conn_id   (s_desc_conn_id),
    .s_desc_len       (s_desc_len),
    .s_data_tvalid    (s_data_tvalid),
    .s_data_tready    (s_data_tready),
    .s_data_tlast     (s_data_tlast),
    .s_data_tdata     (s_data_tdata),
    .s_data_tkeep     (s_data_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tstrb     (m_axis_tstrb),
    .err_len_mismatch (err_len_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (toggle_ready) m_axis_tready = !m_axis_tready;
    else              m_axis_tready = 1'b1;
  end

  // Output monitor: capture transfers, check hold under stall, count error pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", m_axis_tdata[63:0], prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        q_tag.push_back(m_axis_tdata[31:0]);
        q_conn.push_back(m_axis_tdata[529:512]);
        q_strb.push_back(m_axis_tstrb[63:0]);
        q_last.push_back(m_axis_tlast);
      end
      if (err_len_mismatch) err_cycles++;
      if (err_len_mismatch && !prev_err) err_pulses++;
      prev_err   = err_len_mismatch;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata[63:0];
    end
  end

  task automatic clear_obs();
    q_tag.delete(); q_conn.delete(); q_strb.delete(); q_last.delete();
    err_cycles = 0;
    err_pulses = 0;
  endtask

  task automatic send_desc(input logic [17:0] c, input logic [15:0] l);
    int n = 0;
    s_desc_tvalid = 1'b1; s_desc_conn_id = c; s_desc_len = l;
    forever begin
      @(negedge clk);
      if (s_desc_tready) break;
      n++;
      if (n > 200) begin chk("desc_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge clk); #1;
    s_desc_tvalid = 1'b0;
  endtask

  task automatic send_beats(input int nbeats, input int stop_after, input int tag_base,
                            input logic [63:0] last_keep);
    for (int i = 0; i < stop_after; i++) begin
      int n = 0;
      s_data_tvalid = 1'b1;
      s_data_tdata  = 512'(tag_base + i);
      s_data_tlast  = (i == nbeats - 1);
      s_data_tkeep  = (i == nbeats - 1) ? last_keep : ALL1;
      forever begin
        @(negedge clk);
        if (s_data_tready) break;
        n++;
        if (n > 200) begin chk("data_timeout", 64'd0, 64'd1); break; end
      end
      @(posedge clk); #1;
    end
    s_data_tvalid = 1'b0;
    s_data_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (q_tag.size() < n && k < 400) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("beat_count", 64'(q_tag.size()), 64'(n));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; m_axis_tready = 1'b1;
    s_desc_tvalid = 1'b0; s_desc_conn_id = '0; s_desc_len = '0;
    s_data_tvalid = 1'b0; s_data_tlast = 1'b0; s_data_tdata = '0; s_data_tkeep = '0;
    clear_obs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_last",  64'(m_axis_tlast), 64'd0);
    chk("rst_data",  64'(|m_axis_tdata), 64'd0);
    chk("rst_strb",  64'(|m_axis_tstrb), 64'd0);
    chk("rst_err",   64'(err_len_mismatch), 64'd0);
    chk("rst_rdy",   64'({s_desc_tready, s_data_tready}), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_desc_rdy", 64'(s_desc_tready), 64'd1);
    @(posedge clk); #1;

    // len=100, two beats
    clear_obs();
    send_desc(18'h2A, 16'd100);
    send_beats(2, 2, 100, ALL1);
    wait_out(2);
    if (q_tag.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        chk("t1_tag",  64'(q_tag[i]), 64'(100 + i));
        chk("t1_conn", 64'(q_conn[i]), 64'h2A);
        chk("t1_last", 64'(q_last[i]), 64'(i == 1));
      end
      chk("t1_strb0", q_strb[0], ALL1);
      chk("t1_strb1", q_strb[1], 64'h0000_000F_FFFF_FFFF);
    end
    chk("t1_err", 64'(err_cycles), 64'd0);

    // len=2000, 32 beats -> 22 + 10
    clear_obs();
    send_desc(18'h3_1234, 16'd2000);
    send_beats(32, 32, 200, ALL1);
    wait_out(32);
    if (q_tag.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        chk("t2_tag",  64'(q_tag[i]), 64'(200 + i));
        chk("t2_conn", 64'(q_conn[i]), 64'h3_1234);
        chk("t2_last", 64'(q_last[i]), 64'(i == 21 || i == 31));
        chk("t2_strb", q_strb[i], (i == 31) ? 64'hFFFF : ALL1);
      end
    end
    chk("t2_err", 64'(err_cycles), 64'd0);

    // len=128 but tlast on beat 1
    clear_obs();
    send_desc(18'h5, 16'd128);
    send_beats(1, 1, 300, ALL1);
    wait_out(1);
    if (q_tag.size() == 1) begin
      chk("t3_last", 64'(q_last[0]), 64'd1);
      chk("t3_strb", q_strb[0], ALL1);
      chk("t3_tag",  64'(q_tag[0]), 64'd300);
    end
    chk("t3_err_cycles", 64'(err_cycles), 64'd1);
    chk("t3_err_pulses", 64'(err_pulses), 64'd1);
    chk("t3_desc_rdy", 64'(s_desc_tready), 64'd1);

    // len=64 but tlast on beat 3: beats 2-3 drained
    clear_obs();
    send_desc(18'h6, 16'd64);
    send_beats(3, 3, 400, ALL1);
    wait_out(1);
    if (q_tag.size() == 1) begin
      chk("t4_last", 64'(q_last[0]), 64'd1);
      chk("t4_strb", q_strb[0], ALL1);
      chk("t4_tag",  64'(q_tag[0]), 64'd400);
      chk("t4_conn", 64'(q_conn[0]), 64'h6);
    end
    chk("t4_err_cycles", 64'(err_cycles), 64'd1);
    chk("t4_desc_rdy", 64'(s_desc_tready), 64'd1);

    // len=0 descriptor is swallowed
    clear_obs();
    send_desc(18'h7, 16'd0);
    wait_out(0);
    chk("t5_desc_rdy", 64'(s_desc_tready), 64'd1);
    chk("t5_data_rdy", 64'(s_data_tready), 64'd0);

    // len=640 with toggling backpressure
    clear_obs();
    toggle_ready = 1'b1;
    send_desc(18'h8, 16'd640);
    send_beats(10, 10, 500, ALL1);
    wait_out(10);
    toggle_ready = 1'b0;
    if (q_tag.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("t6_tag",  64'(q_tag[i]), 64'(500 + i));
        chk("t6_last", 64'(q_last[i]), 64'(i == 9));
      end
    end
    chk("t6_err", 64'(err_cycles), 64'd0);
    repeat (2) @(posedge clk); #1;

    // len=10 partial keep on final beat
    clear_obs();
    send_desc(18'h9, 16'd10);
    send_beats(1, 1, 600, 64'h0000_0000_0000_0F0F);
    wait_out(1);
    if (q_tag.size() == 1) chk("t7_strb", q_strb[0], 64'h30F);
    chk("t7_err", 64'(err_cycles), 64'd0);

    // reset after beat 5 of a 10-beat message
    clear_obs();
    send_desc(18'hA, 16'd640);
    send_beats(10, 5, 700, ALL1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t8_valid_after_rst", 64'(m_axis_tvalid), 64'd0);
    chk("t8_desc_rdy", 64'(s_desc_tready), 64'd1);
    @(posedge clk); #1;
    clear_obs();
    send_desc(18'hB, 16'd64);
    send_beats(1, 1, 800, ALL1);
    wait_out(1);
    if (q_tag.size() == 1) begin
      chk("t8_tag",  64'(q_tag[0]), 64'd800);
      chk("t8_conn", 64'(q_conn[0]), 64'hB);
      chk("t8_last", 64'(q_last[0]), 64'd1);
      chk("t8_strb", q_strb[0], ALL1);
    end
    chk("t8_err", 64'(err_cycles), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_segmenter.md
UDP_TX_SEGMENTER -- requirements
Module: udp_tx_segmenter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, payload beat width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, payload byte-enable width.
REQ-003 SHALL have parameter CONN_ID_WIDTH, default 18, connection id width.
REQ-004 SHALL have parameter MAX_SEG_BEATS, default 22, maximum beats per output datagram (1408 B).
REQ-005 SHALL have ports: tx_axis_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 tx_axis_rst  in  1  reset, synchronous, active-high.
REQ-007 s_desc_tvalid / s_desc_tready  in / out  1 / 1  message descriptor handshake.
REQ-008 s_desc_conn_id  in  CONN_ID_WIDTH  destination connection id.
REQ-009 s_desc_len  in  16  message length in bytes.
REQ-010 s_data_tvalid / s_data_tready / s_data_tlast  in / out / in  1 each  payload handshake and end of message.
REQ-011 s_data_tdata  in  DATA_WIDTH  payload; s_data_tkeep  in  KEEP_WIDTH  byte enables, byte 0 at bits [7:0].
REQ-012 m_axis_tvalid / m_axis_tready / m_axis_tlast  out / in / out  1 each  datagram stream to the transmit wrapper.
REQ-013 m_axis_tdata  out  544  bits [511:0] payload, [529:512] conn id, [543:530] zero.
REQ-014 m_axis_tstrb  out  68  bits [63:0] byte enables, [67:64] zero.
REQ-015 err_len_mismatch  out  1  one-cycle pulse on descriptor/payload length disagreement.

Function
REQ-016 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-017 IDLE: s_desc_tready=1, s_data_tready=0; on descriptor handshake latch conn_id, rem_bytes=s_desc_len, seg_beat=0, go STREAM.
REQ-018 Descriptor with s_desc_len=0 SHALL be consumed, produce no output, and leave state IDLE.
REQ-019 STREAM: s_desc_tready=0; s_data_tready = !m_axis_tvalid || m_axis_tready.
REQ-020 Output SHALL be one register stage: accepted input beat appears on m_axis the next cycle (latency 1); m_axis_tvalid/data SHALL hold stable while tvalid && !tready.
REQ-021 Each accepted beat: rem_bytes -= 64 saturating at 0; seg_beat += 1, reset to 0 after a beat with m_axis_tlast=1.
REQ-022 m_axis_tlast SHALL be 1 when seg_beat = MAX_SEG_BEATS-1, or rem_bytes <= 64, or s_data_tlast=1.
REQ-023 Final beat of message (rem_bytes <= 64): m_axis_tstrb[63:0] = s_data_tkeep AND mask of lowest rem_bytes bytes; other beats pass s_data_tkeep unmodified.
REQ-024 Every beat of a message SHALL carry the latched conn_id in m_axis_tdata[529:512].
REQ-025 rem_bytes <= 64 with s_data_tlast=1: normal end, go IDLE, no error.
REQ-026 s_data_tlast=1 while rem_bytes > 64: emit beat with m_axis_tlast=1, pulse err_len_mismatch, go IDLE.
REQ-027 rem_bytes <= 64 with s_data_tlast=0: emit beat with m_axis_tlast=1, pulse err_len_mismatch, go DRAIN.
REQ-028 DRAIN: s_data_tready=1, accepted beats discarded (no output); on beat with s_data_tlast=1 go IDLE.
REQ-029 A new descriptor SHALL NOT be accepted until the current message has left STREAM/DRAIN; the output register may still hold the final beat when IDLE accepts the next descriptor.
REQ-030 Output beats SHALL never be dropped or duplicated under any m_axis_tready pattern.

Reset
REQ-031 While tx_axis_rst=1: state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0, err_len_mismatch=0, s_desc_tready=0, s_data_tready=0, counters=0.
REQ-032 Reset asserted mid-message SHALL abandon the message, including any pending output beat; first cycle after deassert is IDLE with s_desc_tready=1.

Verification
REQ-033 len=100, conn 0x2A, 2 beats, tlast on beat 2, tready=1 -> 2 output beats, conn 0x2A, tlast on beat 2 only, beat-2 tstrb[63:0]=0x0000_000F_FFFF_FFFF.
REQ-034 len=2000 (32 beats), tlast on beat 32 -> datagrams of 22 and 10 beats, tlast on output beats 22 and 32, final tstrb low 16 bytes set, no error.
REQ-035 len=128 with tlast on beat 1 -> 1 output beat with tlast, err pulse 1 cycle, next descriptor accepted.
REQ-036 len=64, input tlast on beat 3 -> 1 output beat with tlast, err pulse, input beats 2-3 discarded, return IDLE.
REQ-037 len=640, m_axis_tready toggled 1/0 every cycle -> exactly 10 beats, data stable while stalled, order preserved.
REQ-038 Reset pulse after beat 5 of a 10-beat message -> m_axis_tvalid=0 next cycle, new len=64 message outputs 1 correct beat.
